// File: rtl/bcd_counter_n.sv
// -----------------------------------------------------------------------------
// bcd_counter_n
//
// N-digit BCD up/down counter with an edge-detected run/pause toggle,
// synchronous clear, parallel load, wrap-or-saturate boundary handling and a
// registered terminal-count flag. Each digit feeds one position of the
// 7-segment display driver.
//
// Parameters:
//   NDIG  number of BCD digits (1..8); count width is 4*NDIG
//   WRAP  1 = roll over at a boundary, 0 = hold at the boundary
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   ctrl     run/pause toggle request (rising edge detected internally)
//   dir      0 = count up, 1 = count down
//   clr      synchronous clear of count (highest priority)
//   load     synchronous load of count from din (digits >9 clamp to 9)
//   din      BCD load value, digit 0 in bits [3:0]
//   limit    (CNT_LIMIT_EN only) BCD upper boundary, digits >9 clamp to 9
//   count    registered BCD count
//   running  registered run state
//   tc       registered terminal-count flag (wrap or blocked step)
//
// Optional feature macro: CNT_LIMIT_EN adds the limit port and replaces the
// all-nines upper boundary with the clamped limit value.
// -----------------------------------------------------------------------------
module bcd_counter_n #(
   parameter int NDIG = 3,
   parameter bit WRAP = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ctrl,
   input  logic              dir,
   input  logic              clr,
   input  logic              load,
   input  logic [4*NDIG-1:0] din,
`ifdef CNT_LIMIT_EN
   input  logic [4*NDIG-1:0] limit,
`endif
   output logic [4*NDIG-1:0] count,
   output logic              running,
   output logic              tc
);

   localparam int W = 4 * NDIG;

   logic            ctrl_q;
   logic            rise;
   logic [W-1:0]    din_clamped;
   logic [W-1:0]    upper;
   logic [W-1:0]    inc_val;
   logic [W-1:0]    dec_val;
   logic [W-1:0]    step_val;
   logic [NDIG-1:0] carry;
   logic [NDIG-1:0] borrow;
   logic            at_upper;
   logic            at_zero;
   logic            blocked;

   assign rise = ctrl & ~ctrl_q;

   // Digit 0 always receives the step; higher digits receive a ripple
   // carry/borrow only when every digit below is at its rollover value.
   assign carry[0]  = 1'b1;
   assign borrow[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < NDIG; gi++) begin : g_digit
         logic [3:0] d;
         assign d = count[4*gi +: 4];

         assign din_clamped[4*gi +: 4] = (din[4*gi +: 4] > 4'd9) ? 4'd9 : din[4*gi +: 4];

`ifdef CNT_LIMIT_EN
         assign upper[4*gi +: 4] = (limit[4*gi +: 4] > 4'd9) ? 4'd9 : limit[4*gi +: 4];
`else
         assign upper[4*gi +: 4] = 4'd9;
`endif

         assign inc_val[4*gi +: 4] = carry[gi]  ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
         assign dec_val[4*gi +: 4] = borrow[gi] ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;

         if (gi < NDIG - 1) begin : g_chain
            assign carry[gi+1]  = carry[gi]  & (d == 4'd9);
            assign borrow[gi+1] = borrow[gi] & (d == 4'd0);
         end
      end
   endgenerate

   // Valid BCD orders the same as plain binary, so a binary compare works.
   // ">=" also catches a loaded value that sits above the limit.
   assign at_upper = (count >= upper);
   assign at_zero  = (count == '0);

   always_comb begin
      step_val = count;
      blocked  = 1'b0;
      if (!dir) begin
         if (at_upper) begin
            blocked  = 1'b1;
            step_val = WRAP ? '0 : upper;
         end else begin
            step_val = inc_val;
         end
      end else begin
         if (at_zero) begin
            blocked  = 1'b1;
            step_val = WRAP ? upper : '0;
         end else begin
            step_val = dec_val;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q  <= 1'b0;
         running <= 1'b0;
         count   <= '0;
         tc      <= 1'b0;
      end else begin
         ctrl_q  <= ctrl;
         // Toggle is independent of clr/load/step; the step below still
         // uses the pre-edge running value.
         running <= running ^ rise;
         if (clr) begin
            count <= '0;
            tc    <= 1'b0;
         end else if (load) begin
            count <= din_clamped;
            tc    <= 1'b0;
         end else if (running) begin
            count <= step_val;
            tc    <= blocked;
         end else begin
            tc    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bcd_counter_n.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter_n
//
// Drives a wrapping and a saturating 3-digit counter (plus a 2-digit limited
// counter when CNT_LIMIT_EN is defined) from shared stimulus. A decimal
// integer model predicts every output each cycle; directed literal checks
// pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_bcd_counter_n;

`ifdef CNT_LIMIT_EN
   localparam int NI = 3;
`else
   localparam int NI = 2;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ctrl = 1'b0;
   logic        dir = 1'b0;
   logic        clr = 1'b0;
   logic        load = 1'b0;
   logic [11:0] din = 12'h000;

   logic [11:0] cnt   [3];
   logic        run_o [3];
   logic        tc_o  [3];

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   always #5 clk = ~clk;

`ifdef CNT_LIMIT_EN
   logic [11:0] limit3 = 12'h999;
   logic [7:0]  limit2 = 8'h59;
   logic [7:0]  cnt_lim;
   assign cnt[2] = {4'h0, cnt_lim};
`else
   assign cnt[2]   = 12'h000;
   assign run_o[2] = 1'b0;
   assign tc_o[2]  = 1'b0;
`endif

   bcd_counter_n #(.NDIG(3), .WRAP(1'b1)) u_wrap (
      .clk(clk), .rst(rst), .ctrl(ctrl), .dir(dir), .clr(clr), .load(load),
      .din(din),
`ifdef CNT_LIMIT_EN
      .limit(limit3),
`endif
      .count(cnt[0]), .running(run_o[0]), .tc(tc_o[0]));

   bcd_counter_n #(.NDIG(3), .WRAP(1'b0)) u_sat (
      .clk(clk), .rst(rst), .ctrl(ctrl), .dir(dir), .clr(clr), .load(load),
      .din(din),
`ifdef CNT_LIMIT_EN
      .limit(limit3),
`endif
      .count(cnt[1]), .running(run_o[1]), .tc(tc_o[1]));

`ifdef CNT_LIMIT_EN
   bcd_counter_n #(.NDIG(2), .WRAP(1'b1)) u_lim (
      .clk(clk), .rst(rst), .ctrl(ctrl), .dir(dir), .clr(clr), .load(load),
      .din(din[7:0]), .limit(limit2),
      .count(cnt_lim), .running(run_o[2]), .tc(tc_o[2]));
`endif

   // ---------------- model (decimal integers) ----------------
   int m_val [3];
   bit m_tc  [3];
   bit m_run;
   bit m_ctrl_q;

   function automatic int bcd2int(logic [11:0] v, int nd);
      int r;
      int d;
      r = 0;
      for (int k = nd - 1; k >= 0; k--) begin
         d = int'(v[4*k +: 4]);
         if (d > 9) d = 9;
         r = r * 10 + d;
      end
      return r;
   endfunction

   function automatic logic [11:0] int2bcd(int v);
      logic [11:0] r;
      int x;
      x = v;
      for (int k = 0; k < 3; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int nd_of(int i);
      return (i == 2) ? 2 : 3;
   endfunction

   function automatic int upper_of(int i);
      return (i == 2) ? 59 : 999;
   endfunction

   function automatic bit wrap_of(int i);
      return (i != 1);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run    = 1'b0;
         m_ctrl_q = 1'b0;
         for (int i = 0; i < 3; i++) begin
            m_val[i] = 0;
            m_tc[i]  = 1'b0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            int up;
            up = upper_of(i);
            m_tc[i] = 1'b0;
            if (clr) begin
               m_val[i] = 0;
            end else if (load) begin
               m_val[i] = bcd2int(din, nd_of(i));
            end else if (m_run) begin
               if (!dir) begin
                  if (m_val[i] >= up) begin
                     m_val[i] = wrap_of(i) ? 0 : up;
                     m_tc[i]  = 1'b1;
                  end else begin
                     m_val[i] = m_val[i] + 1;
                  end
               end else begin
                  if (m_val[i] == 0) begin
                     m_val[i] = wrap_of(i) ? up : 0;
                     m_tc[i]  = 1'b1;
                  end else begin
                     m_val[i] = m_val[i] - 1;
                  end
               end
            end
         end
         m_run    = m_run ^ (ctrl & ~m_ctrl_q);
         m_ctrl_q = ctrl;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         for (int i = 0; i < NI; i++) begin
            logic [11:0] exp_c;
            exp_c = int2bcd(m_val[i]);
            n_tests++;
            if (cnt[i] !== exp_c || run_o[i] !== m_run || tc_o[i] !== m_tc[i]) begin
               n_fail++;
               $display("FAIL cmp inst%0d t=%0t count got %h exp %h running got %b exp %b tc got %b exp %b",
                        i, $time, cnt[i], exp_c, run_o[i], m_run, tc_o[i], m_tc[i]);
            end
         end
      end
   end

   // ---------------- directed literal checks ----------------
   task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %h exp %h", nm, act, exp);
      end else begin
         $display("[TB] ok %s = %h", nm, act);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_ctrl();
      ctrl = 1'b1;
      tick();
      ctrl = 1'b0;
   endtask

   task automatic do_load(input logic [11:0] v);
      din  = v;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   initial begin
      tick(2);
      rst = 1'b0;
      check("rst_count", cnt[0], 12'h000);
      check("rst_running", {11'd0, run_o[0]}, 12'h000);
      check("rst_tc", {11'd0, tc_o[0]}, 12'h000);
      chk_en = 1'b1;

      // Wrap up through 999
      do_load(12'h998);
      check("load_998", cnt[0], 12'h998);
      dir = 1'b0;
      pulse_ctrl();
      check("run_on", {11'd0, run_o[0]}, 12'h001);
      check("no_step_on_toggle", cnt[0], 12'h998);
      tick();
      check("up_999", cnt[0], 12'h999);
      check("up_999_tc", {11'd0, tc_o[0]}, 12'h000);
      tick();
      check("wrap_000", cnt[0], 12'h000);
      check("wrap_tc", {11'd0, tc_o[0]}, 12'h001);
      check("sat_hold", cnt[1], 12'h999);
      tick();
      check("after_wrap", cnt[0], 12'h001);
      check("after_wrap_tc", {11'd0, tc_o[0]}, 12'h000);
      pulse_ctrl();
      tick();
      check("paused_run", {11'd0, run_o[0]}, 12'h000);
      check("paused_cnt", cnt[0], 12'h002);

      // Down wrap then reverse
      do_load(12'h000);
      dir = 1'b1;
      pulse_ctrl();
      tick();
      check("down_wrap", cnt[0], 12'h999);
      check("down_wrap_tc", {11'd0, tc_o[0]}, 12'h001);
      check("sat_down_hold", cnt[1], 12'h000);
      dir = 1'b0;
      tick();
      check("reverse_up", cnt[0], 12'h000);
      check("reverse_tc", {11'd0, tc_o[0]}, 12'h001);
      pulse_ctrl();

      // Saturate at 999
      do_load(12'h997);
      pulse_ctrl();
      begin
         logic [11:0] ec [5];
         logic [11:0] et [5];
         ec = '{12'h998, 12'h999, 12'h999, 12'h999, 12'h999};
         et = '{12'h000, 12'h000, 12'h001, 12'h001, 12'h001};
         for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sat_cnt%0d", i), cnt[1], ec[i]);
            check($sformatf("sat_tc%0d", i), {11'd0, tc_o[1]}, et[i]);
         end
      end
      pulse_ctrl();

      // ctrl held high: a single toggle
      do_load(12'h000);
      ctrl = 1'b1;
      tick();
      check("held_run", {11'd0, run_o[0]}, 12'h001);
      tick(5);
      check("held_cnt", cnt[0], 12'h005);
      check("held_still_run", {11'd0, run_o[0]}, 12'h001);
      ctrl = 1'b0;
      tick();
      pulse_ctrl();
      tick(2);
      check("freeze_cnt", cnt[0], 12'h007);
      check("freeze_run", {11'd0, run_o[0]}, 12'h000);

      // Clamp, clr over load
      do_load(12'h9A5);
      check("clamp_load", cnt[0], 12'h995);
      din  = 12'h123;
      clr  = 1'b1;
      load = 1'b1;
      tick();
      clr  = 1'b0;
      load = 1'b0;
      check("clr_over_load", cnt[0], 12'h000);

      // Mixed run with direction changes, a clamped load and a clear
      pulse_ctrl();
      for (int i = 0; i < 24; i++) begin
         dir  = ((i / 5) % 2) == 1;
         clr  = (i == 17);
         load = (i == 10);
         din  = 12'h4C9;
         tick();
      end
      clr  = 1'b0;
      load = 1'b0;
      dir  = 1'b0;
      tick(3);

      // Asynchronous reset mid-cycle
      #2 rst = 1'b1;
      #1;
      check("async_cnt", cnt[0], 12'h000);
      check("async_run", {11'd0, run_o[0]}, 12'h000);
      check("async_cnt_sat", cnt[1], 12'h000);
      tick();
      rst = 1'b0;
      tick();

`ifdef CNT_LIMIT_EN
      do_load(12'h058);
      dir = 1'b0;
      pulse_ctrl();
      tick();
      check("lim_59", cnt[2], 12'h059);
      tick();
      check("lim_wrap", cnt[2], 12'h000);
      check("lim_wrap_tc", {11'd0, tc_o[2]}, 12'h001);
      dir = 1'b1;
      tick();
      check("lim_down", cnt[2], 12'h059);
      check("lim_down_tc", {11'd0, tc_o[2]}, 12'h001);
      pulse_ctrl();
`endif

      tick(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
